// File: rtl/stats_poller_avlstrm_if.sv
`default_nettype none
//------------------------------------------------------------------------------
// Module : avl_stream_if
// Brief  : Single-beat Avalon-ST style link (valid/ready/sop/eop/data).
// Rev    : 1.0  initial release
//------------------------------------------------------------------------------
interface avl_stream_if #(
    parameter int DW = 64
);
    logic          valid;
    logic          ready;
    logic          sop;
    logic          eop;
    logic [DW-1:0] data;

    modport tx (output valid, output sop, output eop, output data, input ready);
    modport rx (input valid, input sop, input eop, input data, output ready);
endinterface
`default_nettype wire

// File: rtl/stats_poller_avlstrm.sv
`default_nettype none
//------------------------------------------------------------------------------
// Module : stats_poller_avlstrm
// Brief  : Sweeps stats registers 0..NUM_RD-1 into a local snapshot with stale
//          flags, and forwards one-deep buffered control-register writes.
// Rev    : 1.0  initial release
//------------------------------------------------------------------------------
module stats_poller_avlstrm #(
    parameter int NUM_RD        = 16,
    parameter int SEL           = 0,
    parameter int SEL_W         = 4,
    parameter int TIMEOUT       = 15,
    parameter int POLL_INTERVAL = 1024
) (
    input  logic        Clk,
    input  logic        Rst_n,
    input  logic        start,
    input  logic        wr_valid,
    output logic        wr_ready,
    input  logic [7:0]  wr_addr,
    input  logic [31:0] wr_data,
    output logic        busy,
    output logic        done,
    output logic [31:0] sweep_cnt,
    output logic [15:0] err_cnt,
    input  logic [7:0]  snap_raddr,
    output logic [31:0] snap_rdata,
    output logic        snap_stale,
    avl_stream_if.tx    stats_rd_req,
    avl_stream_if.tx    stats_wr_req,
    avl_stream_if.rx    stats_rd_resp
);

    localparam int c_IW = (NUM_RD > 1) ? $clog2(NUM_RD) : 1;
    localparam int c_TW = $clog2(TIMEOUT + 1);
    localparam int c_PW = $clog2(POLL_INTERVAL);

    localparam logic [29:0]     c_SEL_WORD  = 30'(SEL) << (30 - SEL_W);
    localparam logic [7:0]      c_LAST_IDX  = 8'(NUM_RD - 1);
    localparam logic [c_TW-1:0] c_TIMEOUT   = c_TW'(TIMEOUT);
    localparam logic [c_PW-1:0] c_POLL_LAST = c_PW'(POLL_INTERVAL - 1);

    localparam logic [1:0] c_IDLE = 2'd0;
    localparam logic [1:0] c_REQ  = 2'd1;
    localparam logic [1:0] c_WAIT = 2'd2;
    localparam logic [1:0] c_NEXT = 2'd3;

    logic [1:0]      r_state;
    logic [7:0]      r_idx;
    logic [c_TW-1:0] r_wait_cnt;
    logic [c_PW-1:0] r_interval;
    logic            r_due;
    logic            r_wr_pend;
    logic [7:0]      r_wr_addr;
    logic [31:0]     r_wr_data;
    logic            r_done;
    logic [31:0]     r_sweep_cnt;
    logic [15:0]     r_err_cnt;
    logic [31:0]     r_snap  [NUM_RD];
    logic            r_stale [NUM_RD];
    logic            r_rd_valid;
    logic [29:0]     r_rd_word;
    logic            r_wr_valid;
    logic [61:0]     r_wr_word;

    logic            w_trigger;
    logic            w_issue_wr;
    logic [c_IW-1:0] w_idx;
    logic [c_IW-1:0] w_raddr;
    logic            w_in_range;
    logic            w_unused;

    assign w_trigger  = start | (r_interval == c_POLL_LAST);
    assign w_issue_wr = r_wr_pend & ((r_state == c_IDLE) | (r_state == c_NEXT));
    assign w_idx      = r_idx[c_IW-1:0];
    assign w_raddr    = snap_raddr[c_IW-1:0];
    assign w_in_range = ({1'b0, snap_raddr} < 9'(NUM_RD));

    always_ff @(posedge Clk) begin
        if (!Rst_n) begin
            r_state     <= c_IDLE;
            r_idx       <= '0;
            r_wait_cnt  <= '0;
            r_interval  <= '0;
            r_due       <= 1'b0;
            r_wr_pend   <= 1'b0;
            r_wr_addr   <= '0;
            r_wr_data   <= '0;
            r_done      <= 1'b0;
            r_sweep_cnt <= '0;
            r_err_cnt   <= '0;
            r_rd_valid  <= 1'b0;
            r_rd_word   <= '0;
            r_wr_valid  <= 1'b0;
            r_wr_word   <= '0;
            for (int i = 0; i < NUM_RD; i++) begin
                r_snap[i]  <= '0;
                r_stale[i] <= 1'b1;
            end
        end else begin
            r_rd_valid <= 1'b0;
            r_wr_valid <= 1'b0;
            r_done     <= 1'b0;
            r_interval <= (r_interval == c_POLL_LAST) ? '0 : r_interval + c_PW'(1);

            if (wr_valid && !r_wr_pend) begin
                r_wr_pend <= 1'b1;
                r_wr_addr <= wr_addr;
                r_wr_data <= wr_data;
            end
            if (w_issue_wr) begin
                r_wr_pend  <= 1'b0;
                r_wr_valid <= 1'b1;
                r_wr_word  <= {c_SEL_WORD | {22'b0, r_wr_addr}, r_wr_data};
            end

            case (r_state)
                c_IDLE: begin
                    if (!r_wr_pend && r_due) begin
                        r_due   <= 1'b0;
                        r_idx   <= '0;
                        r_state <= c_REQ;
                    end
                end
                c_REQ: begin
                    r_rd_valid <= 1'b1;
                    r_rd_word  <= c_SEL_WORD | {22'b0, r_idx};
                    r_wait_cnt <= '0;
                    r_state    <= c_WAIT;
                end
                c_WAIT: begin
                    // A response landing on the timeout cycle still counts as good.
                    if (stats_rd_resp.valid) begin
                        r_snap[w_idx]  <= stats_rd_resp.data[31:0];
                        r_stale[w_idx] <= 1'b0;
                        r_state        <= c_NEXT;
                    end else if (r_wait_cnt == c_TIMEOUT) begin
                        r_stale[w_idx] <= 1'b1;
                        if (r_err_cnt != 16'hFFFF) begin
                            r_err_cnt <= r_err_cnt + 16'd1;
                        end
                        r_state <= c_NEXT;
                    end else begin
                        r_wait_cnt <= r_wait_cnt + c_TW'(1);
                    end
                end
                default: begin
                    if (r_idx == c_LAST_IDX) begin
                        r_done      <= 1'b1;
                        r_sweep_cnt <= r_sweep_cnt + 32'd1;
                        r_state     <= c_IDLE;
                    end else begin
                        r_idx   <= r_idx + 8'd1;
                        r_state <= c_REQ;
                    end
                end
            endcase

            // Placed after the FSM so a trigger in the consuming cycle is not lost.
            if (w_trigger) begin
                r_due <= 1'b1;
            end
        end
    end

    assign wr_ready   = ~r_wr_pend;
    assign busy       = (r_state != c_IDLE);
    assign done       = r_done;
    assign sweep_cnt  = r_sweep_cnt;
    assign err_cnt    = r_err_cnt;
    assign snap_rdata = w_in_range ? r_snap[w_raddr] : 32'd0;
    assign snap_stale = w_in_range ? r_stale[w_raddr] : 1'b1;

    assign stats_rd_req.valid = r_rd_valid;
    assign stats_rd_req.sop   = r_rd_valid;
    assign stats_rd_req.eop   = r_rd_valid;
    assign stats_rd_req.data  = {34'b0, r_rd_word};

    assign stats_wr_req.valid = r_wr_valid;
    assign stats_wr_req.sop   = r_wr_valid;
    assign stats_wr_req.eop   = r_wr_valid;
    assign stats_wr_req.data  = {2'b0, r_wr_word};

    assign stats_rd_resp.ready = 1'b1;

    assign w_unused = &{1'b0, stats_rd_req.ready, stats_wr_req.ready, stats_rd_resp.sop,
                        stats_rd_resp.eop, stats_rd_resp.data[63:32]};

endmodule
`default_nettype wire
